// File: rtl/exp_loader_pkg.sv
// Shared widths, operand indices and FSM states for the modexp operand loader.
package exp_loader_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned OP_W    = 1024;
   localparam int unsigned WORDS   = OP_W / WORD_W;
   localparam int unsigned NUM_OPS = 5;

   typedef enum logic [2:0] {OP_X, OP_M, OP_E, OP_R, OP_R2} op_idx_e;

   typedef enum logic [2:0] {LOAD, SCAN, START, WAIT, DRAIN} state_e;

   // Bit-length of e given the index of its top nonzero word and the MSB position in it.
   function automatic logic [WORD_W-1:0] calc_lene(input logic [4:0] word_idx,
                                                   input logic [4:0] msbpos);
      return WORD_W'({word_idx, 5'b0}) + WORD_W'(msbpos) + WORD_W'(1);
   endfunction

endpackage

// File: rtl/exp_operand_loader_if.sv
// Input stream, result stream, core operand/handshake and status signals of the loader.
interface exp_operand_loader_if;
   import exp_loader_pkg::*;

   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic [OP_W-1:0]   ld_in_x;
   logic [OP_W-1:0]   ld_in_m;
   logic [OP_W-1:0]   ld_in_e;
   logic [OP_W-1:0]   ld_in_r;
   logic [OP_W-1:0]   ld_in_r2;
   logic [WORD_W-1:0] ld_lene;
   logic              ld_start;
   logic [OP_W-1:0]   ld_result;
   logic              ld_done;
   logic              busy;
   logic              err_zero_exp;

   modport master (
      output s_data, s_valid, m_ready, ld_result, ld_done,
      input  s_ready, m_data, m_valid, ld_in_x, ld_in_m, ld_in_e, ld_in_r, ld_in_r2,
             ld_lene, ld_start, busy, err_zero_exp
   );

   modport slave (
      input  s_data, s_valid, m_ready, ld_result, ld_done,
      output s_ready, m_data, m_valid, ld_in_x, ld_in_m, ld_in_e, ld_in_r, ld_in_r2,
             ld_lene, ld_start, busy, err_zero_exp
   );

endinterface

// File: rtl/msb_detect32.sv
// 32-bit priority encoder giving the highest set bit position and a nonzero flag.
// Built only with LOADER_LENE_CALC_EN, the only configuration that instantiates it.
`ifdef LOADER_LENE_CALC_EN
module msb_detect32 (
   input  logic [31:0] word,
   output logic        nonzero,
   output logic [4:0]  msbpos
);

   assign nonzero = |word;

   always_comb begin
      msbpos = '0;
      for (int i = 0; i < 32; i++) begin
         if (word[i]) msbpos = 5'(i);
      end
   end

endmodule
`endif

// File: rtl/exp_operand_loader.sv
// Stream front-end for the modexp core: loads x, m, e, r, r2, starts the core, drains the result.
// LOADER_LENE_CALC_EN: derive lene by scanning e; otherwise lene arrives as a 161st stream word.
module exp_operand_loader
   import exp_loader_pkg::*;
(
   input logic                 clk,
   input logic                 resetn,
   exp_operand_loader_if.slave bus
);

   localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);
   localparam logic [2:0] LAST_OP   = 3'(NUM_OPS - 1);
`ifndef LOADER_LENE_CALC_EN
   localparam logic [2:0] LENE_ITEM = 3'(NUM_OPS);
`endif

   state_e            state_q;
   logic [4:0]        word_cnt_q;
   logic [2:0]        op_cnt_q;
   logic [OP_W-1:0]   ops_q [NUM_OPS];
   logic [OP_W-1:0]   res_q;
   logic [WORD_W-1:0] lene_q;
   logic              s_ready_q;
   logic              m_valid_q;
   logic              ld_start_q;
   logic              busy_q;
   logic              err_q;

   logic s_fire;
   logic m_fire;
   logic last_word;
   logic first_word;

   assign s_fire     = bus.s_valid && s_ready_q;
   assign m_fire     = m_valid_q && bus.m_ready;
   assign last_word  = (word_cnt_q == LAST_WORD);
   assign first_word = (op_cnt_q == '0) && (word_cnt_q == '0);

`ifdef LOADER_LENE_CALC_EN
   logic [4:0]        scan_idx;
   logic [WORD_W-1:0] e_word;
   logic              e_nz;
   logic [4:0]        e_msb;

   // SCAN reuses the word counter upwards and walks e from its top word down.
   assign scan_idx = LAST_WORD - word_cnt_q;
   assign e_word   = ops_q[OP_E][scan_idx*WORD_W +: WORD_W];

   msb_detect32 u_msb (
      .word    (e_word),
      .nonzero (e_nz),
      .msbpos  (e_msb)
   );
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= LOAD;
         word_cnt_q <= '0;
         op_cnt_q   <= '0;
         for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
         res_q      <= '0;
         lene_q     <= '0;
         s_ready_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         ld_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               s_ready_q <= 1'b1;
               if (s_fire) begin
                  busy_q <= 1'b1;
                  if (first_word) err_q <= 1'b0;
`ifdef LOADER_LENE_CALC_EN
                  ops_q[op_cnt_q][word_cnt_q*WORD_W +: WORD_W] <= bus.s_data;
                  word_cnt_q <= word_cnt_q + 5'd1;
                  if (last_word) begin
                     if (op_cnt_q == LAST_OP) begin
                        op_cnt_q  <= '0;
                        s_ready_q <= 1'b0;
                        state_q   <= SCAN;
                     end else begin
                        op_cnt_q <= op_cnt_q + 3'd1;
                     end
                  end
`else
                  if (op_cnt_q == LENE_ITEM) begin
                     op_cnt_q <= '0;
                     // A zero lene would hang the core, so the job ends here.
                     if (bus.s_data == '0) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                     end else begin
                        lene_q     <= bus.s_data;
                        ld_start_q <= 1'b1;
                        s_ready_q  <= 1'b0;
                        state_q    <= START;
                     end
                  end else begin
                     ops_q[op_cnt_q][word_cnt_q*WORD_W +: WORD_W] <= bus.s_data;
                     word_cnt_q <= word_cnt_q + 5'd1;
                     if (last_word) op_cnt_q <= op_cnt_q + 3'd1;
                  end
`endif
               end
            end
`ifdef LOADER_LENE_CALC_EN
            SCAN: begin
               if (e_nz) begin
                  lene_q     <= calc_lene(scan_idx, e_msb);
                  ld_start_q <= 1'b1;
                  word_cnt_q <= '0;
                  state_q    <= START;
               end else if (last_word) begin
                  // e == 0 would hang the core: flag it and never start.
                  err_q      <= 1'b1;
                  busy_q     <= 1'b0;
                  s_ready_q  <= 1'b1;
                  word_cnt_q <= '0;
                  state_q    <= LOAD;
               end else begin
                  word_cnt_q <= word_cnt_q + 5'd1;
               end
            end
`endif
            START: begin
               ld_start_q <= 1'b0;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (bus.ld_done) begin
                  res_q     <= bus.ld_result;
                  m_valid_q <= 1'b1;
                  state_q   <= DRAIN;
               end
            end
            DRAIN: begin
               if (m_fire) begin
                  res_q      <= res_q >> WORD_W;
                  word_cnt_q <= word_cnt_q + 5'd1;
                  if (last_word) begin
                     m_valid_q <= 1'b0;
                     busy_q    <= 1'b0;
                     s_ready_q <= 1'b1;
                     state_q   <= LOAD;
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign bus.s_ready      = s_ready_q;
   assign bus.m_data       = res_q[WORD_W-1:0];
   assign bus.m_valid      = m_valid_q;
   assign bus.ld_in_x      = ops_q[OP_X];
   assign bus.ld_in_m      = ops_q[OP_M];
   assign bus.ld_in_e      = ops_q[OP_E];
   assign bus.ld_in_r      = ops_q[OP_R];
   assign bus.ld_in_r2     = ops_q[OP_R2];
   assign bus.ld_lene      = lene_q;
   assign bus.ld_start     = ld_start_q;
   assign bus.busy         = busy_q;
   assign bus.err_zero_exp = err_q;

endmodule

// File: tb/tb_exp_operand_loader.sv
// Directed jobs through exp_operand_loader with a result-word scoreboard.
// Tracks LOADER_LENE_CALC_EN: without it every job carries a 161st lene word.
module tb_exp_operand_loader;
   import exp_loader_pkg::*;

`ifdef LOADER_LENE_CALC_EN
   localparam int JOB_WORDS = NUM_OPS * WORDS;
`else
   localparam int JOB_WORDS = NUM_OPS * WORDS + 1;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   acc_cnt  = 0;
   logic [WORD_W-1:0] exp_q [$];

   exp_operand_loader_if bus_if ();

   exp_operand_loader dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_if.s_valid && bus_if.s_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) begin
         n_checks++;
         n_pass++;
      end else begin
         n_checks++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int bitlen(input logic [OP_W-1:0] v);
      for (int i = OP_W - 1; i >= 0; i--) begin
         if (v[i]) return i + 1;
      end
      return 0;
   endfunction

   task automatic push_word(input logic [WORD_W-1:0] w);
      int guard = 0;
      if ($urandom_range(0, 3) == 0) begin
         bus_if.s_valid = 1'b0;
         @(negedge clk);
      end
      bus_if.s_data  = w;
      bus_if.s_valid = 1'b1;
      while (!bus_if.s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse(input string tag);
      bus_if.s_valid = 1'b0;
      bus_if.m_ready = 1'b0;
      bus_if.ld_done = 1'b0;
      resetn = 1'b0;
      #1;
      check({tag, ":rst_s_ready"}, 32'(bus_if.s_ready), 32'd0);
      check({tag, ":rst_m_valid"}, 32'(bus_if.m_valid), 32'd0);
      check({tag, ":rst_m_data"}, bus_if.m_data, 32'd0);
      check({tag, ":rst_ld_start"}, 32'(bus_if.ld_start), 32'd0);
      check({tag, ":rst_busy"}, 32'(bus_if.busy), 32'd0);
      check({tag, ":rst_err"}, 32'(bus_if.err_zero_exp), 32'd0);
      check({tag, ":rst_lene"}, bus_if.ld_lene, 32'd0);
      check({tag, ":rst_in_e"}, 32'(|bus_if.ld_in_e), 32'd0);
      exp_q.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check({tag, ":s_ready_after_rst"}, 32'(bus_if.s_ready), 32'd1);
   endtask

   // abort_at: 0 = full job, 1 = reset while WAIT, 2 = reset midway through DRAIN.
   task automatic run_job(input string tag, input logic [OP_W-1:0] e, input logic [31:0] salt,
                          input int abort_at, input bit toggle_ready);
      logic [OP_W-1:0]   ops [NUM_OPS];
      logic [OP_W-1:0]   res;
      logic [WORD_W-1:0] want;
      int                bl, base, lat, exp_lat, guard;
      bit                seen_start, rdy;

      bl   = bitlen(e);
      base = acc_cnt;
      for (int k = 0; k < NUM_OPS; k++) begin
         for (int w = 0; w < WORDS; w++) ops[k][w*WORD_W +: WORD_W] = $urandom;
      end
      ops[int'(OP_E)] = e;
      for (int k = 0; k < NUM_OPS; k++) begin
         for (int w = 0; w < WORDS; w++) push_word(ops[k][w*WORD_W +: WORD_W]);
      end
`ifndef LOADER_LENE_CALC_EN
      push_word(WORD_W'(bl));
`endif

      if (bl == 0) begin
         bus_if.s_valid = 1'b0;
         seen_start = bus_if.ld_start;
         repeat (40) begin
            @(negedge clk);
            if (bus_if.ld_start) seen_start = 1'b1;
         end
         check({tag, ":no_start"}, 32'(seen_start), 32'd0);
         check({tag, ":err_set"}, 32'(bus_if.err_zero_exp), 32'd1);
         check({tag, ":busy_clr"}, 32'(bus_if.busy), 32'd0);
         check({tag, ":s_ready_back"}, 32'(bus_if.s_ready), 32'd1);
         check({tag, ":accepted"}, 32'(acc_cnt - base), 32'(JOB_WORDS));
         return;
      end

      lat = 1;
      while (!bus_if.ld_start && lat < 40) begin
         @(negedge clk);
         lat++;
      end
`ifdef LOADER_LENE_CALC_EN
      exp_lat = 1 + 32 - (bl - 1) / 32;
`else
      exp_lat = 1;
`endif
      check({tag, ":start_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ":lene"}, bus_if.ld_lene, 32'(bl));
      check({tag, ":in_e"}, 32'(bus_if.ld_in_e === e), 32'd1);
      check({tag, ":in_x_w0"}, bus_if.ld_in_x[WORD_W-1:0], ops[0][WORD_W-1:0]);
      check({tag, ":in_r2_top"}, bus_if.ld_in_r2[OP_W-1 -: WORD_W], ops[4][OP_W-1 -: WORD_W]);
      check({tag, ":busy"}, 32'(bus_if.busy), 32'd1);
      check({tag, ":err_clr"}, 32'(bus_if.err_zero_exp), 32'd0);
      @(negedge clk);
      check({tag, ":start_one_cycle"}, 32'(bus_if.ld_start), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, ":wait_s_ready"}, 32'(bus_if.s_ready), 32'd0);
      check({tag, ":wait_lene"}, bus_if.ld_lene, 32'(bl));
      check({tag, ":wait_in_e"}, 32'(bus_if.ld_in_e === e), 32'd1);
      if (abort_at == 1) begin
         reset_pulse({tag, ":wait"});
         return;
      end

      for (int i = 0; i < WORDS; i++) begin
         want = 32'hA5A5_0000 + salt + 32'(i);
         res[i*WORD_W +: WORD_W] = want;
         exp_q.push_back(want);
      end
      bus_if.ld_result = res;
      bus_if.ld_done   = 1'b1;
      @(negedge clk);
      bus_if.ld_done   = 1'b0;
      bus_if.ld_result = '1;
      bus_if.s_valid   = 1'b0;

      guard = 0;
      rdy   = 1'b1;
      while (exp_q.size() > 0 && guard < 200) begin
         bus_if.m_ready = rdy;
         if (bus_if.m_valid && rdy) begin
            if (abort_at == 2 && exp_q.size() == 16) begin
               reset_pulse({tag, ":drain"});
               return;
            end
            want = exp_q.pop_front();
            check({tag, ":m_data"}, bus_if.m_data, want);
         end
         rdy = toggle_ready ? !rdy : 1'b1;
         @(negedge clk);
         guard++;
      end
      bus_if.m_ready = 1'b0;
      check({tag, ":drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, ":m_valid_end"}, 32'(bus_if.m_valid), 32'd0);
      check({tag, ":busy_end"}, 32'(bus_if.busy), 32'd0);
      check({tag, ":accepted"}, 32'(acc_cnt - base), 32'(JOB_WORDS));
      @(negedge clk);
      check({tag, ":s_ready_end"}, 32'(bus_if.s_ready), 32'd1);
   endtask

   initial begin
      logic [OP_W-1:0] e_f4;
      logic [OP_W-1:0] e_top;
      logic [OP_W-1:0] e_mid;

      e_f4  = '0;
      e_f4[WORD_W-1:0] = 32'h0001_0001;
      e_top = '0;
      e_top[OP_W-1] = 1'b1;
      e_mid = '0;
      e_mid[5*WORD_W +: WORD_W] = $urandom | 32'h1;

      bus_if.s_data    = '0;
      bus_if.s_valid   = 1'b0;
      bus_if.m_ready   = 1'b0;
      bus_if.ld_result = '0;
      bus_if.ld_done   = 1'b0;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("reset:s_ready", 32'(bus_if.s_ready), 32'd0);
      check("reset:m_valid", 32'(bus_if.m_valid), 32'd0);
      check("reset:busy", 32'(bus_if.busy), 32'd0);
      check("reset:err", 32'(bus_if.err_zero_exp), 32'd0);
      check("reset:ld_start", 32'(bus_if.ld_start), 32'd0);
      check("reset:lene", bus_if.ld_lene, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("reset:s_ready_rise", 32'(bus_if.s_ready), 32'd1);

      run_job("e65537", e_f4, 32'h0, 0, 1'b1);
      run_job("e1023", e_top, 32'h100, 0, 1'b0);

      // A done pulse outside WAIT must not start a drain.
      bus_if.ld_result = '1;
      bus_if.ld_done   = 1'b1;
      @(negedge clk);
      bus_if.ld_done   = 1'b0;
      @(negedge clk);
      check("stray_done:m_valid", 32'(bus_if.m_valid), 32'd0);
      check("stray_done:busy", 32'(bus_if.busy), 32'd0);

      run_job("ezero", '0, 32'h0, 0, 1'b0);
      run_job("eclr", e_mid, 32'h200, 0, 1'b1);
      run_job("rst_wait", e_f4, 32'h0, 1, 1'b0);
      run_job("rst_drain", e_top, 32'h300, 2, 1'b1);
      run_job("post_rst", e_mid, 32'h400, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
